// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: FU result requests in, grants and CDB broadcast slots out.
// The master modport is the FU/integration side; the slave modport is the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 6,
   parameter int N       = 2,
   parameter int TAG_W   = 6
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     squash;
   logic [NUM_REQ-1:0]       grant;
   logic [N-1:0]             cdb_valid;
   logic [N*TAG_W-1:0]       cdb_tag;
   logic [PTR_W-1:0]         rr_ptr;

   modport master (
      output req_valid, req_tag, squash,
      input  grant, cdb_valid, cdb_tag, rr_ptr
   );

   modport slave (
      input  req_valid, req_tag, squash,
      output grant, cdb_valid, cdb_tag, rr_ptr
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing N CDB broadcast slots among NUM_REQ functional units.
// Grants are combinational; granted tags are registered onto the CDB slots on the
// next edge. The pointer moves just past the last granted requester for fairness.
// Optional starvation guard: define CDB_STARVE_GUARD_EN to give requesters that have
// waited STARVE_LIMIT cycles first claim on the slots. NUM_REQ must be at least 2.
module cdb_arbiter #(
   parameter int NUM_REQ      = 6,
   parameter int N            = 2,
   parameter int TAG_W        = 6,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clock,
   input logic          reset,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SUM_W = PTR_W + 1;

   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_next;
   logic [PTR_W-1:0]   last_idx;
   logic [PTR_W-1:0]   idx;
   logic [SUM_W-1:0]   sum;
   logic [PTR_W-1:0]   slot_idx [N];
   logic [N-1:0]       slot_used;
   logic [NUM_REQ-1:0] grant_c;
   logic [NUM_REQ-1:0] starved;
   logic [N-1:0]       next_valid;
   logic [N*TAG_W-1:0] next_tag;
   logic [N-1:0]       cdb_valid_q;
   logic [N*TAG_W-1:0] cdb_tag_q;
   logic               eligible;
   int                 cnt;

`ifdef CDB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt [NUM_REQ];

   // Per-requester saturating wait counters; cleared on grant, squash or reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
      end else if (bus.squash) begin
         for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i])
               starve_cnt[i] <= '0;
            else if (bus.req_valid[i] && (starve_cnt[i] < SC_W'(STARVE_LIMIT)))
               starve_cnt[i] <= starve_cnt[i] + 1'b1;
         end
      end
   end

   // A requester is starved once its counter has saturated
   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_REQ; i++)
         starved[i] = (starve_cnt[i] == SC_W'(STARVE_LIMIT));
   end
`else
   assign starved = '0;
`endif

   // Two-pass scan from the pointer: starved requesters first, then the normal scan
   always_comb begin
      grant_c   = '0;
      slot_used = '0;
      last_idx  = ptr_q;
      cnt       = 0;
      sum       = '0;
      idx       = '0;
      eligible  = 1'b0;
      for (int k = 0; k < N; k++) slot_idx[k] = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            eligible = bus.req_valid[idx] && !grant_c[idx] && ((p == 1) || starved[idx]);
            if (eligible && (cnt < N)) begin
               grant_c[idx] = 1'b1;
               for (int k = 0; k < N; k++) begin
                  if (k == cnt) begin
                     slot_idx[k]  = idx;
                     slot_used[k] = 1'b1;
                  end
               end
               last_idx = idx;
               cnt = cnt + 1;
            end
         end
      end
      if (bus.squash || reset) begin
         grant_c   = '0;
         slot_used = '0;
         last_idx  = ptr_q;
      end
   end

   // Gather the tags of the granted requesters into slot order and pick the next pointer
   always_comb begin
      next_valid = slot_used;
      next_tag   = '0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (slot_used[k] && (slot_idx[k] == PTR_W'(j)))
               next_tag[k*TAG_W +: TAG_W] = bus.req_tag[j*TAG_W +: TAG_W];
         end
      end
      ptr_next = ptr_q;
      if (|grant_c)
         ptr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
   end

   // CDB slot registers and rotating priority pointer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_valid_q <= '0;
         cdb_tag_q   <= '0;
         ptr_q       <= '0;
      end else begin
         cdb_valid_q <= next_valid;
         cdb_tag_q   <= next_tag;
         ptr_q       <= ptr_next;
      end
   end

   assign bus.grant     = grant_c;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.rr_ptr    = ptr_q;
endmodule
